q_row_reader: RTL and testbench
===============================

// Module: q_row_reader
// PURPOSE
//  Read side of the Q-table BRAM port; the write-side merger is the counterpart. Takes a state S from the control
//  unit, reads its 64-bit Q row (4 x signed 16-bit), unpacks it, and returns the full row plus max Q and argmax action.
//  Sits between control unit and BRAM port B; feeds the Q-update datapath (max_a Q(S',a)).
// PARAMETERS
//  ADDR_WIDTH 32  BRAM byte address width
//  Q_WIDTH    16  signed Q value width; row = 4*Q_WIDTH
//  S_WIDTH    12  state index width
//  A_WIDTH    4   action output width (values 0..3 used)
//  RD_LAT     2   BRAM read latency in cycles, 1..4
// PORTS
//  clk       in  1            clock, all state on rising edge
//  rst       in  1            asynchronous, active-low reset
//  req_valid in  1            read request; S valid
//  req_ready out 1            block can accept request
//  S         in  S_WIDTH      state to read
//  RD_ADDR   out ADDR_WIDTH   BRAM byte address = {zero-ext S, 3'b000}
//  rd_en     out 1            BRAM read enable, one-cycle pulse
//  bram_dout in  4*Q_WIDTH    BRAM row data; Q[a] at bits [16a+15:16a]
//  rsp_valid out 1            response valid; held until accepted
//  rsp_ready in  1            consumer accepts response
//  Qrow      out 4*Q_WIDTH    registered row as read
//  Qmax      out Q_WIDTH      signed max of the 4 Q values
//  A_max     out A_WIDTH      index of Qmax, zero-extended
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE; req_ready=1, rd_en=0, rsp_valid=0, RD_ADDR=0, Qrow=0, Qmax=0, A_max=0.
//  - FSM IDLE -> WAIT -> CMP -> HOLD -> IDLE.
//    IDLE: req_ready=1; on req_valid&req_ready, register RD_ADDR from S, pulse rd_en 1 cycle, go WAIT.
//    WAIT: count RD_LAT cycles from the rd_en cycle; on last, capture bram_dout into Qrow, go CMP.
//    CMP: two-level signed compare tree, registered; go HOLD with rsp_valid=1.
//    HOLD: outputs stable; on rsp_ready go IDLE (rsp_valid=0 next cycle).
//  - Latency req accept -> rsp_valid = RD_LAT+2 cycles (4 at default). One outstanding request; req_ready=0
//    outside IDLE. rsp_ready asserted with rsp_valid -> throughput one request per RD_LAT+3 cycles.
//  - Compare: signed two's complement; ties -> lowest action index (all equal -> A_max=0).
//  - Extremes: 0x8000 and 0x7FFF handled with no overflow (compare only, no arithmetic).
//  - S at max (0xFFF) -> RD_ADDR=0x7FF8; no wrap, upper address bits zero.
//  - rsp_ready when rsp_valid=0 ignored; req_valid outside IDLE ignored (not queued).
//  - Reset mid-operation: abort immediately, no rsp issued, outputs to reset values.
// CONFIGURATION
//  QROW_FWD_EN defined: adds ports wr_en(1), WR_ADDR(ADDR_WIDTH), Dnew(4*Q_WIDTH), wen_bram(8) observing the write
//   side. If a write with WR_ADDR==RD_ADDR occurs in any cycle from rd_en through the capture cycle, its enabled
//   bytes (wen_bram[i] -> byte i) are merged over bram_dout at capture; later writes take priority. Read-after-write
//   coherent.
//  Not defined: ports absent; Qrow = raw bram_dout (write-side stall guarantees coherence).
// STRUCTURE
//  Shared package q_pkg: Q_WIDTH, S_WIDTH, A_WIDTH, N_ACT=4, ROW_BYTES=8, state enum (IDLE/WAIT/CMP/HOLD), row
//   unpack function q_of(row,a).
//  Sub-module q_argmax4: combinational 4-way signed max/argmax with lowest-index tie-break; reused by
//   epsilon-greedy selector.
// TESTING (bench models BRAM with RD_LAT latency, rsp_ready random unless stated)
//  1 Reset: rst=0 mid-WAIT -> rsp_valid=0, req_ready=1, all outputs 0 within same cycle (async).
//  2 S=0x005, row {Q3,Q2,Q1,Q0}={0x0010,0xFFF0,0x0200,0x0001} -> RD_ADDR=0x28, Qmax=0x0200, A_max=1,
//    rsp_valid 4 cycles after accept.
//  3 Row all 0x8000 -> Qmax=0x8000, A_max=0; row {0x7FFF,0x7FFF,0x0,0x0} -> Qmax=0x7FFF, A_max=2.
//  4 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid, Qrow, Qmax, A_max stable; req_ready=0;
//    new req_valid ignored.
//  5 S=0xFFF -> RD_ADDR=0x00007FF8; back-to-back requests with rsp_ready=1 -> one rsp per 5 cycles.
//  6 QROW_FWD_EN: write WR_ADDR=RD_ADDR, wen_bram=0x03, Dnew[15:0]=0x1234 in WAIT -> Qrow[15:0]=0x1234,
//    other bytes from BRAM.

Source files
------------

// File: rtl/q_row_reader_pkg.sv
// rtl/q_row_reader_pkg.sv - shared Q-table widths, FSM state type and row unpack helper
// Package q_pkg: Q_WIDTH, S_WIDTH, A_WIDTH, N_ACT, ROW_BYTES, ROW_WIDTH,
// rd_state_t (IDLE/WAIT/CMP/HOLD), q_of(row, a) returns signed Q[a] of a packed row.
package q_pkg;

    localparam int Q_WIDTH   = 16;
    localparam int S_WIDTH   = 12;
    localparam int A_WIDTH   = 4;
    localparam int N_ACT     = 4;
    localparam int ROW_BYTES = 8;
    localparam int ROW_WIDTH = N_ACT * Q_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CMP  = 2'd2,
        HOLD = 2'd3
    } rd_state_t;

    // Q[a] lives at bits [Q_WIDTH*a + Q_WIDTH-1 : Q_WIDTH*a]
    function automatic logic signed [Q_WIDTH-1:0] q_of(input logic [ROW_WIDTH-1:0] row,
                                                       input int a);
        return row[a*Q_WIDTH +: Q_WIDTH];
    endfunction

endpackage

// File: rtl/q_row_reader_if.sv
// rtl/q_row_reader_if.sv - request/response handshake between control unit and row reader
// Signals: req_valid/req_ready/S (request), rsp_valid/rsp_ready/Qrow/Qmax/A_max (response).
// Modports: master = control unit side, slave = q_row_reader side.
interface q_row_reader_if;
    import q_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [S_WIDTH-1:0]   S;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ROW_WIDTH-1:0] Qrow;
    logic [Q_WIDTH-1:0]   Qmax;
    logic [A_WIDTH-1:0]   A_max;

    modport master (
        output req_valid, S, rsp_ready,
        input  req_ready, rsp_valid, Qrow, Qmax, A_max
    );

    modport slave (
        input  req_valid, S, rsp_ready,
        output req_ready, rsp_valid, Qrow, Qmax, A_max
    );

endinterface

// File: rtl/q_row_reader_argmax4.sv
// rtl/q_row_reader_argmax4.sv - combinational 4-way signed max/argmax, lowest index wins ties
// Ports: row (in, packed 4 x Q), qmax (out, signed max), amax (out, 2-bit index of qmax).
module q_argmax4
    import q_pkg::*;
(
    input  logic [ROW_WIDTH-1:0]      row,
    output logic signed [Q_WIDTH-1:0] qmax,
    output logic [1:0]                amax
);

    logic signed [Q_WIDTH-1:0] q0, q1, q2, q3;
    logic signed [Q_WIDTH-1:0] lo_q, hi_q;
    logic [1:0]                lo_a, hi_a;

    // Strict '>' everywhere: a later candidate only wins when strictly larger,
    // and the low pair is the default at the second level, so ties resolve to
    // the lowest action index. Compare only, so 0x8000/0x7FFF cannot overflow.
    always_comb begin
        q0 = q_of(row, 0);
        q1 = q_of(row, 1);
        q2 = q_of(row, 2);
        q3 = q_of(row, 3);

        lo_q = q0;
        lo_a = 2'd0;
        if (q1 > q0) begin
            lo_q = q1;
            lo_a = 2'd1;
        end

        hi_q = q2;
        hi_a = 2'd2;
        if (q3 > q2) begin
            hi_q = q3;
            hi_a = 2'd3;
        end

        qmax = lo_q;
        amax = lo_a;
        if (hi_q > lo_q) begin
            qmax = hi_q;
            amax = hi_a;
        end
    end

endmodule

// File: rtl/q_row_reader.sv
// rtl/q_row_reader.sv - reads one Q row from BRAM port B, returns row, max Q and argmax action
// Ports: clk, rst (async active-low), ctl (q_row_reader_if.slave: request S, response Qrow/Qmax/A_max),
//        RD_ADDR/rd_en (BRAM address and one-cycle read pulse), bram_dout (BRAM row data).
// Optional macro QROW_FWD_EN adds wr_en/WR_ADDR/Dnew/wen_bram: same-address writes seen between
//        the rd_en cycle and the capture cycle are byte-merged over bram_dout (later writes win).
module q_row_reader
    import q_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LAT     = 2
)
(
    input  logic                  clk,
    input  logic                  rst,
    q_row_reader_if.slave         ctl,
    output logic [ADDR_WIDTH-1:0] RD_ADDR,
    output logic                  rd_en,
    input  logic [ROW_WIDTH-1:0]  bram_dout
`ifdef QROW_FWD_EN
    ,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [ROW_WIDTH-1:0]  Dnew,
    input  logic [ROW_BYTES-1:0]  wen_bram
`endif
);

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    rd_state_t                 state;
    logic [2:0]                lat_cnt;
    logic                      req_ready_q;
    logic                      rsp_valid_q;
    logic [ROW_WIDTH-1:0]      qrow_q;
    logic [Q_WIDTH-1:0]        qmax_q;
    logic [A_WIDTH-1:0]        amax_q;

    logic [ADDR_WIDTH-1:0]     addr_of_s;
    logic [ROW_WIDTH-1:0]      cap_row;
    logic signed [Q_WIDTH-1:0] qmax_c;
    logic [1:0]                amax_c;

    // One row is 8 bytes, so the byte address is S shifted by 3, zero-extended.
    assign addr_of_s = ADDR_WIDTH'({ctl.S, 3'b000});

`ifdef QROW_FWD_EN
    logic [ROW_WIDTH-1:0] fwd_data;
    logic [ROW_BYTES-1:0] fwd_mask;
    logic [ROW_WIDTH-1:0] fwd_data_nxt;
    logic [ROW_BYTES-1:0] fwd_mask_nxt;
    logic                 wr_hit;

    // Merge state including this cycle's write, so a write landing in the
    // capture cycle itself is still seen and overrides earlier ones.
    always_comb begin
        wr_hit       = wr_en && (WR_ADDR == RD_ADDR);
        fwd_data_nxt = fwd_data;
        fwd_mask_nxt = fwd_mask;
        cap_row      = bram_dout;
        for (int i = 0; i < ROW_BYTES; i++) begin
            if (wr_hit && wen_bram[i]) begin
                fwd_data_nxt[i*8 +: 8] = Dnew[i*8 +: 8];
                fwd_mask_nxt[i]        = 1'b1;
            end
            if (fwd_mask_nxt[i]) begin
                cap_row[i*8 +: 8] = fwd_data_nxt[i*8 +: 8];
            end
        end
    end
`else
    assign cap_row = bram_dout;
`endif

    q_argmax4 u_argmax (
        .row  (qrow_q),
        .qmax (qmax_c),
        .amax (amax_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rd_en       <= 1'b0;
            RD_ADDR     <= '0;
            qrow_q      <= '0;
            qmax_q      <= '0;
            amax_q      <= '0;
`ifdef QROW_FWD_EN
            fwd_data    <= '0;
            fwd_mask    <= '0;
`endif
        end else begin
            rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctl.req_valid) begin
                        RD_ADDR     <= addr_of_s;
                        rd_en       <= 1'b1;
                        req_ready_q <= 1'b0;
                        lat_cnt     <= '0;
`ifdef QROW_FWD_EN
                        fwd_mask    <= '0;
`endif
                        state       <= WAIT;
                    end
                end
                // WAIT lasts RD_LAT cycles, the first being the rd_en cycle.
                WAIT: begin
`ifdef QROW_FWD_EN
                    fwd_data <= fwd_data_nxt;
                    fwd_mask <= fwd_mask_nxt;
`endif
                    if (lat_cnt == LAT_LAST) begin
                        qrow_q <= cap_row;
                        state  <= CMP;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                CMP: begin
                    qmax_q      <= qmax_c;
                    amax_q      <= A_WIDTH'(amax_c);
                    rsp_valid_q <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (ctl.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ctl.req_ready = req_ready_q;
    assign ctl.rsp_valid = rsp_valid_q;
    assign ctl.Qrow      = qrow_q;
    assign ctl.Qmax      = qmax_q;
    assign ctl.A_max     = amax_q;

endmodule

// File: tb/tb_q_row_reader.sv
// tb/tb_q_row_reader.sv - directed table-driven bench for q_row_reader (QROW_FWD_EN optional)
module tb_q_row_reader;
    import q_pkg::*;

    logic                 clk;
    logic                 rst;
    logic [31:0]          RD_ADDR;
    logic                 rd_en;
    logic [ROW_WIDTH-1:0] bram_dout;
    logic [ROW_WIDTH-1:0] mem_row;
`ifdef QROW_FWD_EN
    logic                 wr_en;
    logic [31:0]          WR_ADDR;
    logic [ROW_WIDTH-1:0] Dnew;
    logic [ROW_BYTES-1:0] wen_bram;
`endif

    int total = 0;
    int bad   = 0;

    q_row_reader_if ctl_if ();

    q_row_reader #(.ADDR_WIDTH(32), .RD_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctl       (ctl_if),
        .RD_ADDR   (RD_ADDR),
        .rd_en     (rd_en),
        .bram_dout (bram_dout)
`ifdef QROW_FWD_EN
        ,
        .wr_en     (wr_en),
        .WR_ADDR   (WR_ADDR),
        .Dnew      (Dnew),
        .wen_bram  (wen_bram)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model, RD_LAT=2 counted from the rd_en cycle: one register stage
    // after rd_en is sampled. Junk when not reading exposes mistimed capture.
    always @(posedge clk) begin
        if (rd_en) bram_dout <= mem_row;
        else       bram_dout <= 64'hBAD0_BAD1_BAD2_BAD3;
    end

    typedef struct {
        logic [11:0] s;
        logic [63:0] row;
        logic [31:0] addr;
        logic [15:0] qmax;
        logic [3:0]  amax;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for rsp_valid; returns the cycle count since req_valid was raised.
    task automatic wait_rsp(input int start, output int n);
        n = start;
        while (!ctl_if.rsp_valid && n < 20) begin
            ctl_if.rsp_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
            if (n == 2) chk("rd_en_single_pulse", 64'(rd_en), 64'd0);
        end
        ctl_if.rsp_ready = 1'b0;
    endtask

    task automatic run_req(input vec_t v);
        int n;
        int k;
        chk("pre_req_ready", 64'(ctl_if.req_ready), 64'd1);
        mem_row          = v.row;
        ctl_if.S         = v.s;
        ctl_if.req_valid = 1'b1;
        tick();
        ctl_if.req_valid = 1'b0;
        chk("rd_en_pulse", 64'(rd_en), 64'd1);
        chk("rd_addr", 64'(RD_ADDR), 64'(v.addr));
        chk("req_ready_busy", 64'(ctl_if.req_ready), 64'd0);
        wait_rsp(1, n);
        chk("latency", 64'(n), 64'd4);
        chk("qrow", ctl_if.Qrow, v.row);
        chk("qmax", 64'(ctl_if.Qmax), 64'(v.qmax));
        chk("amax", 64'(ctl_if.A_max), 64'(v.amax));
        k = $urandom_range(0, 3);
        repeat (k) tick();
        chk("hold_valid", 64'(ctl_if.rsp_valid), 64'd1);
        ctl_if.rsp_ready = 1'b1;
        tick();
        ctl_if.rsp_ready = 1'b0;
        chk("rsp_drop", 64'(ctl_if.rsp_valid), 64'd0);
        chk("idle_ready", 64'(ctl_if.req_ready), 64'd1);
    endtask

    initial begin
        int n;
        int seen;
        int rsp_t[$];
        logic [63:0] held_row;

        vecs[0] = '{12'h005, 64'h0010_FFF0_0200_0001, 32'h0000_0028, 16'h0200, 4'd1};
        vecs[1] = '{12'h001, 64'h8000_8000_8000_8000, 32'h0000_0008, 16'h8000, 4'd0};
        vecs[2] = '{12'h100, 64'h7FFF_7FFF_0000_0000, 32'h0000_0800, 16'h7FFF, 4'd2};
        vecs[3] = '{12'hFFF, 64'h0001_0002_0003_0004, 32'h0000_7FF8, 16'h0004, 4'd0};
        vecs[4] = '{12'h000, 64'h1111_1111_1111_1111, 32'h0000_0000, 16'h1111, 4'd0};
        vecs[5] = '{12'hABC, 64'hFFFF_FFFE_8000_8001, 32'h0000_55E0, 16'hFFFF, 4'd3};
        vecs[6] = '{12'h7FF, 64'h7FFF_8000_8000_8000, 32'h0000_3FF8, 16'h7FFF, 4'd3};
        vecs[7] = '{12'h002, 64'h0005_0005_FFFF_0000, 32'h0000_0010, 16'h0005, 4'd2};
        vecs[8] = '{12'h003, 64'h0003_0007_0007_0002, 32'h0000_0018, 16'h0007, 4'd1};

        rst              = 1'b0;
        ctl_if.req_valid = 1'b0;
        ctl_if.rsp_ready = 1'b0;
        ctl_if.S         = '0;
        mem_row          = '0;
`ifdef QROW_FWD_EN
        wr_en    = 1'b0;
        WR_ADDR  = '0;
        Dnew     = '0;
        wen_bram = '0;
`endif
        repeat (3) tick();
        chk("rst_req_ready", 64'(ctl_if.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(ctl_if.rsp_valid), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_rd_addr", 64'(RD_ADDR), 64'd0);
        chk("rst_qrow", ctl_if.Qrow, 64'd0);
        chk("rst_qmax", 64'(ctl_if.Qmax), 64'd0);
        chk("rst_amax", 64'(ctl_if.A_max), 64'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_req(vecs[i]);

        // Async reset in the middle of WAIT: outputs clear with no clock edge.
        mem_row          = 64'h0100_0200_0300_0400;
        ctl_if.S         = 12'h044;
        ctl_if.req_valid = 1'b1;
        tick();
        ctl_if.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_rsp_valid", 64'(ctl_if.rsp_valid), 64'd0);
        chk("arst_req_ready", 64'(ctl_if.req_ready), 64'd1);
        chk("arst_rd_en", 64'(rd_en), 64'd0);
        chk("arst_rd_addr", 64'(RD_ADDR), 64'd0);
        chk("arst_qrow", ctl_if.Qrow, 64'd0);
        chk("arst_qmax", 64'(ctl_if.Qmax), 64'd0);
        chk("arst_amax", 64'(ctl_if.A_max), 64'd0);
        tick();
        rst = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            if (ctl_if.rsp_valid || rd_en) seen++;
        end
        chk("arst_no_rsp", 64'(seen), 64'd0);

        // Backpressure: response held 10 cycles, new requests ignored.
        mem_row          = vecs[0].row;
        ctl_if.S         = vecs[0].s;
        ctl_if.req_valid = 1'b1;
        tick();
        ctl_if.req_valid = 1'b0;
        wait_rsp(1, n);
        chk("bp_latency", 64'(n), 64'd4);
        held_row         = ctl_if.Qrow;
        chk("bp_row", held_row, vecs[0].row);
        ctl_if.S         = 12'h0AA;
        mem_row          = 64'h7000_7000_7000_7000;
        ctl_if.req_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_valid", 64'(ctl_if.rsp_valid), 64'd1);
            chk("bp_qrow", ctl_if.Qrow, held_row);
            chk("bp_qmax", 64'(ctl_if.Qmax), 64'h0200);
            chk("bp_amax", 64'(ctl_if.A_max), 64'd1);
            chk("bp_req_ready", 64'(ctl_if.req_ready), 64'd0);
            chk("bp_no_rd", 64'(rd_en), 64'd0);
        end
        ctl_if.req_valid = 1'b0;
        ctl_if.rsp_ready = 1'b1;
        tick();
        ctl_if.rsp_ready = 1'b0;
        chk("bp_release", 64'(ctl_if.rsp_valid), 64'd0);
        seen = 0;
        repeat (6) begin
            tick();
            if (ctl_if.rsp_valid || rd_en) seen++;
        end
        chk("bp_not_queued", 64'(seen), 64'd0);

        // Back-to-back with rsp_ready held high: one response every 5 cycles.
        mem_row          = vecs[3].row;
        ctl_if.S         = 12'hFFF;
        ctl_if.req_valid = 1'b1;
        ctl_if.rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ctl_if.rsp_valid) begin
                rsp_t.push_back(c);
                chk("b2b_qmax", 64'(ctl_if.Qmax), 64'h0004);
            end
        end
        ctl_if.req_valid = 1'b0;
        ctl_if.rsp_ready = 1'b0;
        chk("b2b_count", 64'(rsp_t.size()), 64'd4);
        chk("b2b_addr", 64'(RD_ADDR), 64'h7FF8);
        for (int j = 1; j < rsp_t.size(); j++)
            chk("b2b_period", 64'(rsp_t[j] - rsp_t[j-1]), 64'd5);
        chk("b2b_idle", 64'(ctl_if.req_ready), 64'd1);

`ifdef QROW_FWD_EN
        // Same-address writes in both WAIT cycles merge over BRAM data,
        // the later one overriding byte 0; an off-address write is ignored.
        mem_row          = 64'h1111_2222_3333_4444;
        ctl_if.S         = 12'h005;
        ctl_if.req_valid = 1'b1;
        tick();
        ctl_if.req_valid = 1'b0;
        wr_en    = 1'b1;
        WR_ADDR  = 32'h28;
        Dnew     = 64'h0000_0000_0000_1234;
        wen_bram = 8'h03;
        tick();
        WR_ADDR  = 32'h28;
        Dnew     = 64'h0000_0000_0000_0056;
        wen_bram = 8'h01;
        tick();
        WR_ADDR  = 32'h30;
        Dnew     = 64'hFFFF_FFFF_FFFF_FFFF;
        wen_bram = 8'hFF;
        tick();
        wr_en    = 1'b0;
        wen_bram = '0;
        wait_rsp(4, n);
        chk("fwd_latency", 64'(n), 64'd4);
        chk("fwd_qrow", ctl_if.Qrow, 64'h1111_2222_3333_1256);
        chk("fwd_qmax", 64'(ctl_if.Qmax), 64'h3333);
        chk("fwd_amax", 64'(ctl_if.A_max), 64'd1);
        ctl_if.rsp_ready = 1'b1;
        tick();
        ctl_if.rsp_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
